axi_mst_engine: RTL and testbench
=================================

AXI_MST_ENGINE -- requirements
Module: axi_mst_engine

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 32, address width of cmd_addr, awaddr and araddr.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, data width; strobe width is DATA_WIDTH/8.
REQ-003 The block SHALL have parameter ID_WIDTH, default 8, width of all ID fields.
REQ-004 The block SHALL have port aclk, input, 1 bit, clock, all logic on its rising edge.
REQ-005 The block SHALL have port aresetn, input, 1 bit, reset, asynchronous, active-low.
REQ-006 The block SHALL have port cmd_valid/cmd_ready, input/output, 1 bit each, command handshake.
REQ-007 The block SHALL have port cmd_write, input, 1 bit: 1 selects write, 0 selects read.
REQ-008 The block SHALL have port cmd_id, input, ID_WIDTH: transaction ID.
REQ-009 The block SHALL have ports cmd_addr, cmd_len, cmd_size and cmd_burst, inputs, ADDR_WIDTH, 8, 3 and 2 bits: burst attributes.
REQ-010 The block SHALL have port wr_data, input, DATA_WIDTH, and port wr_strb, input, DATA_WIDTH/8: write beat source.
REQ-011 The block SHALL have port wr_valid, input, 1 bit, and port wr_ready, output, 1 bit: write beat source handshake.
REQ-012 The block SHALL have ports rd_data, rd_valid and rd_last, outputs, DATA_WIDTH, 1 and 1 bit: read beat sink, always accepted.
REQ-013 The block SHALL have ports done, done_resp and done_err, outputs, 1, 2 and 1 bit: completion pulse, worst response, protocol error.
REQ-014 The block SHALL have AW channel outputs awid, awaddr, awlen, awsize, awburst and awvalid, and input awready.
REQ-015 The block SHALL have W channel outputs wid, wdata, wstrb (DATA_WIDTH/8), wlast and wvalid, and input wready.
REQ-016 The block SHALL have B channel inputs bid, bresp and bvalid, and output bready.
REQ-017 The block SHALL have AR channel outputs arid, araddr, arlen, arsize, arburst and arvalid, and input arready.
REQ-018 The block SHALL have R channel inputs rid, rdata, rresp, rlast and rvalid, and output rready.

Function
REQ-019 The FSM SHALL have states IDLE, AW, W, B, AR, R and DONE, with one transaction outstanding at a time.
REQ-020 cmd_ready SHALL be 1 only in IDLE; a cmd_valid&&cmd_ready cycle SHALL register all cmd_* fields and go to AW (write) or AR (read).
REQ-021 A command with cmd_burst=2'b11, or with cmd_burst=WRAP and cmd_len not in {1,3,7,15}, SHALL go directly to DONE with done_resp=SLVERR, done_err=1, and no bus activity.
REQ-022 In AW/AR, awvalid/arvalid SHALL assert from the cycle after acceptance and hold, with stable fields, until awready/arready is sampled high.
REQ-023 In W, wvalid SHALL equal wr_valid, wdata/wstrb SHALL equal wr_data/wr_strb, wr_ready SHALL equal wready, and wid SHALL equal the registered ID.
REQ-024 An 8-bit beat counter SHALL clear on entry to W/R and increment per handshake; wlast=1 when count==len, so len=0 gives wlast on the first beat.
REQ-025 After the wlast handshake the FSM SHALL enter B; bready=1 only in B; on bvalid it SHALL capture bresp, set done_err if bid!=ID, and go to DONE.
REQ-026 In R, rready SHALL be 1, and rd_data/rd_valid/rd_last SHALL equal rdata/(rvalid&&rready)/rlast.
REQ-027 done_resp SHALL hold the numerically maximum rresp over all beats.
REQ-028 done_err SHALL set if rlast differs from (count==len) on any beat or if rid!=ID; R SHALL exit on the beat where count==len, regardless of rlast.
REQ-029 DONE SHALL last exactly one cycle with done=1, then return to IDLE; minimum write latency from acceptance to done is 4 cycles with zero-wait slaves.
REQ-030 All AXI valid and ready outputs not owned by the current state SHALL be 0.

Reset
REQ-031 On aresetn=0 the block SHALL asynchronously enter IDLE, clear the counter, and drive all valid/ready/done/err outputs and done_resp to 0; cmd_ready SHALL be 1 after release.
REQ-032 Reset mid-transaction SHALL abandon the transaction with no completion pulse.

Structure
REQ-033 Package axi_pkg SHALL hold the burst enum (FIXED/INCR/WRAP), resp enum (OKAY/EXOKAY/SLVERR/DECERR), and the FSM state typedef.
REQ-034 The block SHALL be a single module with no sub-module.

Verification
REQ-035 Write, len=3, INCR, zero-wait slave, bresp=OKAY -> 4 W beats, wlast on 4th, done 4+3 cycles after accept, done_resp=0, done_err=0.
REQ-036 Read, len=0, rresp=OKAY then a read len=2 with rresp {0,2,0} -> done_resp=0, then done_resp=2 (SLVERR).
REQ-037 Read, len=3, slave asserts rlast on beat 2 -> done_err=1, exit after 4th beat.
REQ-038 cmd_burst=WRAP, len=2 -> no awvalid, done next cycle, done_resp=2, done_err=1.
REQ-039 Write with awready held low 5 cycles, wready toggling -> awaddr stable throughout; beat count is exact; bid mismatch -> done_err=1.
REQ-040 aresetn pulsed low during the W state -> all valids 0 within the same cycle, no done pulse, next command proceeds normally.

Source files
------------

// File: rtl/axi_pkg.sv
// ---------------------------------------------------------------------------
// axi_pkg
//   Shared AXI types for the master engine: burst and response encodings,
//   the engine FSM state type, and a helper that recognises commands the
//   engine refuses to put on the bus.
// ---------------------------------------------------------------------------
package axi_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } burst_e;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AW   = 3'd1,
    ST_W    = 3'd2,
    ST_B    = 3'd3,
    ST_AR   = 3'd4,
    ST_R    = 3'd5,
    ST_DONE = 3'd6
  } state_e;

  // Reserved burst type, or a WRAP burst whose beat count is not 2/4/8/16.
  function automatic logic burst_illegal(input logic [1:0] burst,
                                         input logic [7:0] len);
    logic wrap_len_ok;
    wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    return (burst == 2'b11) || ((burst == BURST_WRAP) && !wrap_len_ok);
  endfunction

endpackage

// File: rtl/axi_mst_engine.sv
// ---------------------------------------------------------------------------
// axi_mst_engine
//   Single-outstanding AXI master. A command (cmd_*) is accepted in IDLE and
//   turned into one AW/W/B write or one AR/R read transaction; a one-cycle
//   done pulse reports the worst response (done_resp) and any protocol error
//   seen from the slave (done_err).
//
// Ports
//   aclk, aresetn            clock, asynchronous active-low reset
//   cmd_*                    command handshake and burst attributes
//   wr_data/wr_strb/wr_valid/wr_ready   write beat source (passes to W)
//   rd_data/rd_valid/rd_last read beat sink (always accepted)
//   done/done_resp/done_err  completion pulse and status
//   aw*/w*/b*/ar*/r*         AXI master channels
// ---------------------------------------------------------------------------
module axi_mst_engine
  import axi_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 8
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  // command
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ID_WIDTH-1:0]     cmd_id,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [7:0]              cmd_len,
  input  logic [2:0]              cmd_size,
  input  logic [1:0]              cmd_burst,
  // write beat source
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH/8-1:0] wr_strb,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  // read beat sink
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_valid,
  output logic                    rd_last,
  // completion
  output logic                    done,
  output logic [1:0]              done_resp,
  output logic                    done_err,
  // AW
  output logic [ID_WIDTH-1:0]     awid,
  output logic [ADDR_WIDTH-1:0]   awaddr,
  output logic [7:0]              awlen,
  output logic [2:0]              awsize,
  output logic [1:0]              awburst,
  output logic                    awvalid,
  input  logic                    awready,
  // W
  output logic [ID_WIDTH-1:0]     wid,
  output logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH/8-1:0] wstrb,
  output logic                    wlast,
  output logic                    wvalid,
  input  logic                    wready,
  // B
  input  logic [ID_WIDTH-1:0]     bid,
  input  logic [1:0]              bresp,
  input  logic                    bvalid,
  output logic                    bready,
  // AR
  output logic [ID_WIDTH-1:0]     arid,
  output logic [ADDR_WIDTH-1:0]   araddr,
  output logic [7:0]              arlen,
  output logic [2:0]              arsize,
  output logic [1:0]              arburst,
  output logic                    arvalid,
  input  logic                    arready,
  // R
  input  logic [ID_WIDTH-1:0]     rid,
  input  logic [DATA_WIDTH-1:0]   rdata,
  input  logic [1:0]              rresp,
  input  logic                    rlast,
  input  logic                    rvalid,
  output logic                    rready
);

  state_e                  state_reg, state_next;
  logic [ID_WIDTH-1:0]     id_reg;
  logic [ADDR_WIDTH-1:0]   addr_reg;
  logic [7:0]              len_reg;
  logic [2:0]              size_reg;
  logic [1:0]              burst_reg;
  logic [7:0]              count_reg;
  logic [1:0]              resp_reg;
  logic                    err_reg;

  logic cmd_illegal;
  logic beat_is_last;

  assign cmd_illegal  = burst_illegal(cmd_burst, cmd_len);
  assign beat_is_last = (count_reg == len_reg);

  // ---------------- state register ----------------
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state_reg <= ST_IDLE;
    else          state_reg <= state_next;
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (cmd_valid) begin
          if (cmd_illegal)    state_next = ST_DONE;
          else if (cmd_write) state_next = ST_AW;
          else                state_next = ST_AR;
        end
      end
      ST_AW:   if (awready) state_next = ST_W;
      // wvalid mirrors wr_valid, so the W handshake is wr_valid && wready
      ST_W:    if (wr_valid && wready && beat_is_last) state_next = ST_B;
      ST_B:    if (bvalid) state_next = ST_DONE;
      ST_AR:   if (arready) state_next = ST_R;
      // leave on the expected last beat whatever the slave says about rlast
      ST_R:    if (rvalid && beat_is_last) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // ---------------- output logic ----------------
  always_comb begin
    cmd_ready = 1'b0;
    awvalid   = 1'b0;
    wvalid    = 1'b0;
    wr_ready  = 1'b0;
    wlast     = 1'b0;
    bready    = 1'b0;
    arvalid   = 1'b0;
    rready    = 1'b0;
    rd_valid  = 1'b0;
    rd_last   = 1'b0;
    done      = 1'b0;
    case (state_reg)
      // gated so the command port reads not-ready while reset is held
      ST_IDLE: cmd_ready = aresetn;
      ST_AW:   awvalid   = 1'b1;
      ST_W: begin
        wvalid   = wr_valid;
        wr_ready = wready;
        wlast    = beat_is_last;
      end
      ST_B:    bready    = 1'b1;
      ST_AR:   arvalid   = 1'b1;
      ST_R: begin
        rready   = 1'b1;
        rd_valid = rvalid;
        rd_last  = rlast;
      end
      ST_DONE: done      = 1'b1;
      default: ;
    endcase
  end

  // ---------------- command, beat counter and status ----------------
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      id_reg    <= '0;
      addr_reg  <= '0;
      len_reg   <= '0;
      size_reg  <= '0;
      burst_reg <= '0;
      count_reg <= '0;
      resp_reg  <= '0;
      err_reg   <= 1'b0;
    end else begin
      if (state_reg == ST_IDLE && cmd_valid) begin
        id_reg    <= cmd_id;
        addr_reg  <= cmd_addr;
        len_reg   <= cmd_len;
        size_reg  <= cmd_size;
        burst_reg <= cmd_burst;
        resp_reg  <= cmd_illegal ? RESP_SLVERR : RESP_OKAY;
        err_reg   <= cmd_illegal;
      end

      // counter idles at zero outside the data phases, so it is clear on entry
      if (state_reg == ST_W) begin
        if (wr_valid && wready) count_reg <= count_reg + 8'd1;
      end else if (state_reg == ST_R) begin
        if (rvalid) count_reg <= count_reg + 8'd1;
      end else begin
        count_reg <= '0;
      end

      if (state_reg == ST_B && bvalid) begin
        resp_reg <= bresp;
        if (bid != id_reg) err_reg <= 1'b1;
      end

      if (state_reg == ST_R && rvalid) begin
        if (rresp > resp_reg) resp_reg <= rresp;
        if ((rlast != beat_is_last) || (rid != id_reg)) err_reg <= 1'b1;
      end
    end
  end

  // ---------------- datapath pass-through ----------------
  assign awid      = id_reg;
  assign awaddr    = addr_reg;
  assign awlen     = len_reg;
  assign awsize    = size_reg;
  assign awburst   = burst_reg;
  assign arid      = id_reg;
  assign araddr    = addr_reg;
  assign arlen     = len_reg;
  assign arsize    = size_reg;
  assign arburst   = burst_reg;
  assign wid       = id_reg;
  assign wdata     = wr_data;
  assign wstrb     = wr_strb;
  assign rd_data   = rdata;
  assign done_resp = resp_reg;
  assign done_err  = err_reg;

endmodule

// File: tb/tb_axi_mst_engine.sv
// ---------------------------------------------------------------------------
// tb_axi_mst_engine
//   Drives commands, plays the AXI slave and the beat source, and checks each
//   transaction against expectations computed from the burst plan.
// ---------------------------------------------------------------------------
module tb_axi_mst_engine;

  logic        aclk, aresetn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [7:0]  cmd_id;
  logic [31:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic [2:0]  cmd_size;
  logic [1:0]  cmd_burst;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;
  logic        wr_valid, wr_ready;
  logic [31:0] rd_data;
  logic        rd_valid, rd_last;
  logic        done;
  logic [1:0]  done_resp;
  logic        done_err;
  logic [7:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid, awready;
  logic [7:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast, wvalid, wready;
  logic [7:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid, bready;
  logic [7:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid, arready;
  logic [7:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;

  axi_mst_engine #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(8)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_id(cmd_id), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .cmd_size(cmd_size), .cmd_burst(cmd_burst),
    .wr_data(wr_data), .wr_strb(wr_strb), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last),
    .done(done), .done_resp(done_resp), .done_err(done_err),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int n_checks = 0;
  int n_pass   = 0;
  int txn_no   = 0;

  logic [31:0] wdata_arr  [0:256];
  logic [3:0]  wstrb_arr  [0:256];
  logic [31:0] rdata_arr  [0:256];
  logic [1:0]  rresp_plan [0:256];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp)
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    else
      n_pass++;
  endtask

  task automatic idle_inputs();
    cmd_valid = 0; cmd_write = 0; cmd_id = 0; cmd_addr = 0; cmd_len = 0;
    cmd_size = 0; cmd_burst = 0; wr_data = 0; wr_strb = 0; wr_valid = 0;
    awready = 0; wready = 0; bid = 0; bresp = 0; bvalid = 0; arready = 0;
    rid = 0; rdata = 0; rresp = 0; rlast = 0; rvalid = 0;
  endtask

  function automatic logic rnd_bit();
    return ($urandom_range(0, 1) == 1);
  endfunction

  // One complete command. rst_at > 0 pulses reset in that cycle after accept.
  task automatic run_txn(input bit wr, input logic [7:0] len, input logic [1:0] burst,
                         input int addr_wait, input bit rand_ready, input bit bad_id,
                         input int bad_last, input logic [1:0] bresp_plan, input int rst_at);
    logic [7:0]  id;
    logic [31:0] addr;
    logic [2:0]  size;
    bit   illegal, zero_wait, a_done, w_done, b_done, bus_act, drv_last;
    int   addr_cycles, addr_hs, widx, rbeat, cyc, exp_beats, exp_lat;
    logic [1:0] exp_resp;
    logic exp_err;

    id   = 8'($urandom_range(0, 255));
    addr = $urandom;
    size = 3'($urandom_range(0, 2));
    for (int k = 0; k <= 256; k++) begin
      wdata_arr[k] = $urandom;
      wstrb_arr[k] = 4'($urandom_range(0, 15));
      rdata_arr[k] = $urandom;
    end

    // expectations from the command rules
    illegal = (burst == 2'b11) ||
              (burst == 2'b10 && !(len == 1 || len == 3 || len == 7 || len == 15));
    zero_wait = (addr_wait == 0) && !rand_ready;
    if (illegal) begin
      exp_resp = 2'd2; exp_err = 1'b1; exp_beats = 0; exp_lat = 1;
    end else if (wr) begin
      exp_resp = bresp_plan; exp_err = bad_id; exp_beats = int'(len) + 1;
      exp_lat = int'(len) + 4;
    end else begin
      exp_resp = 2'd0;
      for (int k = 0; k <= int'(len); k++)
        if (rresp_plan[k] > exp_resp) exp_resp = rresp_plan[k];
      exp_err = bad_id || (bad_last >= 0 && bad_last <= int'(len));
      exp_beats = int'(len) + 1;
      exp_lat = int'(len) + 3;
    end

    a_done = 0; w_done = 0; b_done = 0; bus_act = 0;
    addr_cycles = 0; addr_hs = 0; widx = 0; rbeat = 0;

    @(negedge aclk);
    cmd_valid = 1; cmd_write = wr; cmd_id = id; cmd_addr = addr;
    cmd_len = len; cmd_size = size; cmd_burst = burst;
    #1 check_eq("cmd_ready", cmd_ready, 1);
    @(negedge aclk);
    idle_inputs();
    cyc = 1;
    while (1) begin
      awready  = (addr_cycles >= addr_wait);
      arready  = (addr_cycles >= addr_wait);
      wready   = rand_ready ? rnd_bit() : 1'b1;
      wr_valid = rand_ready ? rnd_bit() : 1'b1;
      wr_data  = wdata_arr[widx];
      wr_strb  = wstrb_arr[widx];
      bvalid   = w_done && !b_done;
      bid      = bad_id ? (id ^ 8'h01) : id;
      bresp    = bresp_plan;
      rvalid   = a_done && !wr && (rbeat <= int'(len)) && (rand_ready ? rnd_bit() : 1'b1);
      rdata    = rdata_arr[rbeat];
      rresp    = rresp_plan[rbeat & 255];
      drv_last = (rbeat == int'(len)) ^ (rbeat == bad_last);
      rlast    = drv_last;
      rid      = bad_id ? (id ^ 8'h01) : id;
      #1;
      if (rst_at == cyc) begin
        check_eq("pre_rst_wvalid", wvalid, 1);
        aresetn = 0;
        #1 check_eq("rst_outputs",
                    {awvalid, wvalid, wr_ready, bready, arvalid, rready, rd_valid, done, done_err, done_resp},
                    11'd0);
        @(negedge aclk);
        idle_inputs();
        #2 aresetn = 1;
        for (int k = 0; k < 3; k++) begin
          @(negedge aclk);
          #1 check_eq("no_done_after_rst", done, 0);
        end
        check_eq("cmd_ready_after_rst", cmd_ready, 1);
        $display("txn %0d reset-abandoned write len=%0d at cycle %0d", txn_no, len, cyc);
        txn_no++;
        return;
      end
      if (awvalid || arvalid || wvalid || bready || rready) bus_act = 1;
      if (awvalid) begin
        check_eq("aw_fields", {awid, awaddr, awlen, awsize, awburst, arvalid},
                 {id, addr, len, size, burst, 1'b0});
        if (awready) begin a_done = 1; addr_hs++; end else addr_cycles++;
      end
      if (arvalid) begin
        check_eq("ar_fields", {arid, araddr, arlen, arsize, arburst, awvalid},
                 {id, addr, len, size, burst, 1'b0});
        if (arready) begin a_done = 1; addr_hs++; end else addr_cycles++;
      end
      if (wvalid && wready) begin
        check_eq("w_beat", {wlast, wid, wstrb, wdata, wr_ready},
                 {(widx == int'(len)), id, wstrb_arr[widx], wdata_arr[widx], 1'b1});
        if (widx == int'(len)) w_done = 1;
        widx++;
      end
      if (bvalid && bready) b_done = 1;
      if (rvalid && rready) begin
        check_eq("r_beat", {rd_valid, rd_last, rd_data}, {1'b1, drv_last, rdata_arr[rbeat]});
        rbeat++;
      end
      if (done) begin
        check_eq("done_resp", done_resp, exp_resp);
        check_eq("done_err", done_err, exp_err);
        check_eq("beats", wr ? widx : rbeat, exp_beats);
        check_eq("addr_handshakes", addr_hs, illegal ? 0 : 1);
        if (illegal) check_eq("no_bus_activity", bus_act, 0);
        if (zero_wait || illegal) check_eq("latency", cyc, exp_lat);
        break;
      end
      if (cyc > 600) begin
        check_eq("timeout_no_done", 0, 1);
        break;
      end
      @(negedge aclk);
      cyc++;
    end
    @(negedge aclk);
    idle_inputs();
    #1 check_eq("after_done", {done, cmd_ready}, 2'b01);
    $display("txn %0d %s len=%0d burst=%0d resp=%0d err=%0d cycles=%0d",
             txn_no, wr ? "write" : "read", len, burst, done_resp, done_err, cyc);
    txn_no++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    aresetn = 0;
    for (int k = 0; k <= 256; k++) rresp_plan[k] = 2'd0;
    repeat (3) @(negedge aclk);
    #1 check_eq("reset_outputs",
                {awvalid, wvalid, wr_ready, bready, arvalid, rready, rd_valid, done, done_err, done_resp},
                11'd0);
    aresetn = 1;
    @(negedge aclk);
    #1 check_eq("reset_release", {cmd_ready, done, done_resp}, 4'b1000);

    // write len=3 INCR, zero-wait, OKAY
    run_txn(1, 8'd3, 2'b01, 0, 0, 0, -1, 2'd0, 0);
    // read len=0 OKAY, then len=2 with responses {0,2,0}
    run_txn(0, 8'd0, 2'b01, 0, 0, 0, -1, 2'd0, 0);
    rresp_plan[1] = 2'd2;
    run_txn(0, 8'd2, 2'b01, 0, 0, 0, -1, 2'd0, 0);
    rresp_plan[1] = 2'd0;
    // read len=3 with early rlast on the second beat
    run_txn(0, 8'd3, 2'b01, 0, 0, 0, 1, 2'd0, 0);
    // illegal commands: WRAP len=2, reserved burst
    run_txn(1, 8'd2, 2'b10, 0, 0, 0, -1, 2'd0, 0);
    run_txn(0, 8'd5, 2'b11, 0, 0, 0, -1, 2'd0, 0);
    // legal WRAP len=3
    run_txn(1, 8'd3, 2'b10, 0, 0, 0, -1, 2'd1, 0);
    // awready held low 5 cycles, random wready, wrong bid
    run_txn(1, 8'd5, 2'b01, 5, 1, 1, -1, 2'd3, 0);
    // reset during W, then a normal write
    run_txn(1, 8'd7, 2'b01, 0, 0, 0, -1, 2'd0, 4);
    run_txn(1, 8'd1, 2'b00, 0, 0, 0, -1, 2'd0, 0);

    // randomized commands
    for (int t = 0; t < 40; t++) begin
      for (int k = 0; k <= 256; k++) rresp_plan[k] = 2'($urandom_range(0, 3));
      run_txn(rnd_bit(), 8'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
              $urandom_range(0, 3), rnd_bit(), ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 2) == 0) ? $urandom_range(0, 15) : -1,
              2'($urandom_range(0, 3)), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
